// File: rtl/regbank_access_ctrl_pkg.sv
// Shared definitions for the register-bank access controller and the UART
// debug unit that consumes its dump channel.
//   - dump_state_t : 3-bit encoded dump sequencer states
//   - DBG_BANK_SIZE / DBG_DATA_W : default bank geometry seen by the debug channel
//   - idx_width()  : register index width for a given bank size
package regbank_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_READ      = 3'd2,
    ST_HOLD      = 3'd3,
    ST_DONE      = 3'd4
  } dump_state_t;

  localparam int DBG_BANK_SIZE = 32;
  localparam int DBG_DATA_W    = 32;

  // A one-entry bank still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbank_access_ctrl.sv
// Arbitration and sequencing controller placed in front of registers_bank.
// Normal operation: pipeline read port 1 and write port pass straight through.
// Dump: on i_dbg_dump_start the pipeline is asked to halt, then every register
// is streamed out one beat at a time over a valid/ready channel.
// While halted and idle, single debug writes may use the bank write port.
//
// Ports:
//   i_clk, i_reset                      clock, asynchronous active-high reset
//   i_pipe_read_register_1              pipeline read index A
//   i_pipe_write_enable/_register/_data pipeline write-back request
//   i_pipe_halted                       pipeline drained and frozen
//   o_halt_request                      halt request to the pipeline
//   o_read_register_1, i_read_data_1    bank read port A (asynchronous read)
//   o_write_enable/_register/_data      bank write port
//   i_dbg_dump_start                    one-cycle dump request
//   o_dbg_data/_index/_valid/_last      dump beat, i_dbg_ready accepts it
//   o_dbg_done                          one-cycle pulse at end of dump
//   i_dbg_write_valid/_register/_data   debug write request
//   o_dbg_write_ready                   debug write accepted this cycle
module regbank_access_ctrl
  import regbank_access_ctrl_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = DBG_BANK_SIZE,
  parameter int REGISTERS_SIZE      = DBG_DATA_W,
  localparam int IDX_W              = idx_width(REGISTERS_BANK_SIZE)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [IDX_W-1:0]          i_pipe_read_register_1,
  input  logic                      i_pipe_write_enable,
  input  logic [IDX_W-1:0]          i_pipe_write_register,
  input  logic [REGISTERS_SIZE-1:0] i_pipe_write_data,
  input  logic                      i_pipe_halted,
  output logic                      o_halt_request,
  output logic [IDX_W-1:0]          o_read_register_1,
  input  logic [REGISTERS_SIZE-1:0] i_read_data_1,
  output logic                      o_write_enable,
  output logic [IDX_W-1:0]          o_write_register,
  output logic [REGISTERS_SIZE-1:0] o_write_data,
  input  logic                      i_dbg_dump_start,
  output logic [REGISTERS_SIZE-1:0] o_dbg_data,
  output logic [IDX_W-1:0]          o_dbg_index,
  output logic                      o_dbg_valid,
  output logic                      o_dbg_last,
  input  logic                      i_dbg_ready,
  output logic                      o_dbg_done,
  input  logic                      i_dbg_write_valid,
  input  logic [IDX_W-1:0]          i_dbg_write_register,
  input  logic [REGISTERS_SIZE-1:0] i_dbg_write_data,
  output logic                      o_dbg_write_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REGISTERS_BANK_SIZE - 1);

  dump_state_t               state_p0;
  dump_state_t               state_nxt;
  logic [IDX_W-1:0]          index_p0;
  logic [IDX_W-1:0]          index_nxt;
  logic [REGISTERS_SIZE-1:0] dump_data_p1;
  logic [IDX_W-1:0]          dump_index_p1;
  logic                      dbg_write_ready;

  // Stage p0: sequencer state and read index
  // Stage p1: captured beat, held stable for the consumer while in HOLD
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_p0      <= ST_IDLE;
      index_p0      <= '0;
      dump_data_p1  <= '0;
      dump_index_p1 <= '0;
    end else begin
      state_p0 <= state_nxt;
      index_p0 <= index_nxt;
      if (state_p0 == ST_READ) begin
        dump_data_p1  <= i_read_data_1;
        dump_index_p1 <= index_p0;
      end
    end
  end

  always_comb begin
    state_nxt      = state_p0;
    index_nxt      = index_p0;
    o_halt_request = 1'b0;
    o_dbg_valid    = 1'b0;
    o_dbg_last     = 1'b0;
    o_dbg_done     = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        if (i_dbg_dump_start) state_nxt = ST_WAIT_HALT;
      end
      ST_WAIT_HALT: begin
        o_halt_request = 1'b1;
        if (i_pipe_halted) begin
          state_nxt = ST_READ;
          index_nxt = '0;
        end
      end
      ST_READ: begin
        o_halt_request = 1'b1;
        state_nxt      = ST_HOLD;
      end
      ST_HOLD: begin
        o_halt_request = 1'b1;
        o_dbg_valid    = 1'b1;
        o_dbg_last     = (dump_index_p1 == LAST_IDX);
        if (i_dbg_ready) begin
          // The last index leads to DONE, so the increment never wraps.
          if (dump_index_p1 == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            index_nxt = index_p0 + 1'b1;
            state_nxt = ST_READ;
          end
        end
      end
      ST_DONE: begin
        o_dbg_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_dbg_data  = dump_data_p1;
  assign o_dbg_index = dump_index_p1;

  // Read port A belongs to the sequencer only while it is fetching a beat.
  assign o_read_register_1 = (state_p0 == ST_READ) ? index_p0 : i_pipe_read_register_1;

  // Debug writes only land while the pipeline is frozen and no dump is in
  // progress, so a dump is always a consistent snapshot.
  assign dbg_write_ready   = i_dbg_write_valid & i_pipe_halted & ~i_pipe_write_enable
                             & (state_p0 == ST_IDLE);
  assign o_dbg_write_ready = dbg_write_ready;

  // Pipeline write-back always wins; index 0 is forwarded untouched since the
  // bank itself protects register 0.
  always_comb begin
    o_write_enable   = i_pipe_write_enable;
    o_write_register = i_pipe_write_register;
    o_write_data     = i_pipe_write_data;
    if (!i_pipe_write_enable && dbg_write_ready) begin
      o_write_enable   = 1'b1;
      o_write_register = i_dbg_write_register;
      o_write_data     = i_dbg_write_data;
    end
  end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
module tb_regbank_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  pipe_rd;
  logic        pipe_we;
  logic [4:0]  pipe_wr;
  logic [31:0] pipe_wd;
  logic        halted;
  logic        halt_req;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
  logic        we;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        dump_start;
  logic [31:0] dbg_data;
  logic [4:0]  dbg_index;
  logic        dbg_valid;
  logic        dbg_last;
  logic        dbg_ready;
  logic        dbg_done;
  logic        dwv;
  logic [4:0]  dwr;
  logic [31:0] dwd;
  logic        dw_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regbank_access_ctrl dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_pipe_read_register_1 (pipe_rd),
    .i_pipe_write_enable    (pipe_we),
    .i_pipe_write_register  (pipe_wr),
    .i_pipe_write_data      (pipe_wd),
    .i_pipe_halted          (halted),
    .o_halt_request         (halt_req),
    .o_read_register_1      (rd_idx),
    .i_read_data_1          (rd_data),
    .o_write_enable         (we),
    .o_write_register       (wr_idx),
    .o_write_data           (wr_data),
    .i_dbg_dump_start       (dump_start),
    .o_dbg_data             (dbg_data),
    .o_dbg_index            (dbg_index),
    .o_dbg_valid            (dbg_valid),
    .o_dbg_last             (dbg_last),
    .i_dbg_ready            (dbg_ready),
    .o_dbg_done             (dbg_done),
    .i_dbg_write_valid      (dwv),
    .i_dbg_write_register   (dwr),
    .i_dbg_write_data       (dwd),
    .o_dbg_write_ready      (dw_ready)
  );

  // Behavioural register bank: async read, sync write, register 0 reads zero.
  logic [31:0] bank [32];
  logic        bank_init;

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
  endfunction

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
    end else if (we && wr_idx != 5'd0) begin
      bank[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (rd_idx == 5'd0) ? 32'h0 : bank[rd_idx];

  // Bank contents expected after the directed writes of the vector table.
  function automatic logic [31:0] exp_reg(input int i);
    if (i == 0) return 32'h0;
    if (i == 3) return 32'h0000_0011;
    if (i == 5) return 32'hDEAD_BEEF;
    return init_val(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  prd;
    logic        pwe;
    logic [4:0]  pwr;
    logic [31:0] pwd;
    logic        hlt;
    logic        dv;
    logic [4:0]  dr;
    logic [31:0] dd;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [6];

  // One full dump. bp_beat: beat held off by 10 cycles of ready=0 (-1 none);
  // poke: issue a start pulse and a debug write at beat 10;
  // rst_beat: assert reset while this beat is presented (-1 none).
  task automatic run_dump(input int bp_beat, input bit poke, input int rst_beat);
    int  beats;
    int  extra;
    bit  done_seen;
    bit  aborted;
    beats     = 0;
    extra     = 0;
    done_seen = 1'b0;
    aborted   = 1'b0;
    dbg_ready = 1'b1;
    halted    = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wait_halt_req", 32'(halt_req), 32'd1);
      chk("wait_halt_no_valid", 32'(dbg_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    halted = 1'b1;
    for (int cyc = 0; cyc < 600 && !done_seen && !aborted; cyc++) begin
      @(negedge clk);
      if (dbg_done) begin
        done_seen = 1'b1;
        chk("done_halt_req", 32'(halt_req), 32'd0);
      end else if (dbg_valid) begin
        if (rst_beat >= 0 && beats == rst_beat) begin
          rst = 1'b1;
          #1;
          chk("rst_mid_valid", 32'(dbg_valid), 32'd0);
          chk("rst_mid_halt_req", 32'(halt_req), 32'd0);
          chk("rst_mid_rd_passthru", 32'(rd_idx), 32'(pipe_rd));
          tick();
          rst = 1'b0;
          aborted = 1'b1;
        end else begin
          if (beats == bp_beat) begin
            dbg_ready = 1'b0;
            for (int k = 0; k < 10; k++) begin
              @(negedge clk);
              chk("bp_valid", 32'(dbg_valid), 32'd1);
              chk("bp_index", 32'(dbg_index), 32'(bp_beat));
              chk("bp_data", dbg_data, exp_reg(bp_beat));
            end
            dbg_ready = 1'b1;
          end
          chk("beat_index", 32'(dbg_index), 32'(beats));
          chk("beat_data", dbg_data, exp_reg(beats));
          chk("beat_last", 32'(dbg_last), (beats == 31) ? 32'd1 : 32'd0);
          chk("beat_halt_req", 32'(halt_req), 32'd1);
          beats++;
          if (poke && beats == 11) begin
            dump_start = 1'b1;
            dwv = 1'b1;
            dwr = 5'd9;
            dwd = 32'h0000_0077;
            #1;
            chk("mid_dump_dw_ready", 32'(dw_ready), 32'd0);
            chk("mid_dump_we", 32'(we), 32'd0);
            tick();
            dump_start = 1'b0;
            dwv = 1'b0;
          end
        end
      end
    end
    if (!aborted) begin
      chk("dump_beats", 32'(beats), 32'd32);
      chk("dump_done_seen", 32'(done_seen), 32'd1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (dbg_done || dbg_valid) extra++;
      end
      chk("post_dump_quiet", 32'(extra), 32'd0);
      chk("post_dump_halt_req", 32'(halt_req), 32'd0);
    end
    halted = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'd3,  1'b1, 5'd3, 32'h11,        1'b0, 1'b0, 5'd0, 32'h0,
                5'd3,  1'b1, 5'd3, 32'h11,        1'b0};
    vecs[1] = '{5'd3,  1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF,
                5'd3,  1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1};
    vecs[2] = '{5'd7,  1'b1, 5'd3, 32'h11,        1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF,
                5'd7,  1'b1, 5'd3, 32'h11,        1'b0};
    vecs[3] = '{5'd9,  1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 5'd6, 32'h55,
                5'd9,  1'b0, 5'd0, 32'h0,         1'b0};
    vecs[4] = '{5'd0,  1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 5'd0, 32'h1234,
                5'd0,  1'b1, 5'd0, 32'h1234,      1'b1};
    vecs[5] = '{5'd31, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 5'd0, 32'h0,
                5'd31, 1'b0, 5'd0, 32'h0,         1'b0};

    rst = 1'b1;
    bank_init = 1'b1;
    pipe_rd = 5'd0; pipe_we = 1'b0; pipe_wr = 5'd0; pipe_wd = 32'h0;
    halted = 1'b0; dump_start = 1'b0; dbg_ready = 1'b1;
    dwv = 1'b0; dwr = 5'd0; dwd = 32'h0;
    tick();
    tick();
    chk("rst_halt_req", 32'(halt_req), 32'd0);
    chk("rst_valid", 32'(dbg_valid), 32'd0);
    chk("rst_last", 32'(dbg_last), 32'd0);
    chk("rst_done", 32'(dbg_done), 32'd0);
    chk("rst_dbg_data", dbg_data, 32'd0);
    chk("rst_dbg_index", 32'(dbg_index), 32'd0);
    rst = 1'b0;
    bank_init = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      pipe_rd = vecs[v].prd; pipe_we = vecs[v].pwe;
      pipe_wr = vecs[v].pwr; pipe_wd = vecs[v].pwd;
      halted  = vecs[v].hlt; dwv = vecs[v].dv;
      dwr     = vecs[v].dr;  dwd = vecs[v].dd;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", v), 32'(rd_idx), 32'(vecs[v].e_rd));
      chk($sformatf("vec%0d_we", v), 32'(we), 32'(vecs[v].e_we));
      if (vecs[v].e_we) begin
        chk($sformatf("vec%0d_wr", v), 32'(wr_idx), 32'(vecs[v].e_wr));
        chk($sformatf("vec%0d_wd", v), wr_data, vecs[v].e_wd);
      end
      chk($sformatf("vec%0d_dw_ready", v), 32'(dw_ready), 32'(vecs[v].e_rdy));
      chk($sformatf("vec%0d_idle_dbg", v),
          32'({dbg_valid, dbg_last, dbg_done, halt_req}), 32'd0);
      tick();
    end
    pipe_we = 1'b0; dwv = 1'b0; halted = 1'b0; pipe_rd = 5'd17;
    tick();

    run_dump(-1, 1'b0, -1);
    run_dump(7, 1'b0, -1);
    run_dump(-1, 1'b1, -1);
    run_dump(-1, 1'b0, 12);
    tick();
    run_dump(-1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
